// File: rtl/score_display_driver.sv
// Score display driver: serial shift-add-3 BCD conversion, 4-digit AN/SEG scan, LED outcome flash.
// Latency: score change to new digits 11 clk; AN/SEG/LED are registered (1 clk after their sources).
// Backpressure: none; pure sink of the game core, inputs are sampled every clk.
module score_display_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int FLASH_LEN = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] score,
    input  logic [3:0] pattern,
    input  logic       round_tick,
    input  logic       round_res,
    output logic [3:0] AN,
    output logic [7:0] SEG,
    output logic [7:0] LED
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int FLASH_W = $clog2(FLASH_LEN + 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_LEN);

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_LOAD,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         digit_idx_q, digit_idx_d;
    logic [3:0]         an_q, an_d;
    logic [7:0]         seg_q, seg_d;
    logic [7:0]         led_q, led_d;
    conv_state_t        conv_state_q, conv_state_d;
    logic [7:0]         latched_score_q, latched_score_d;
    logic [11:0]        bcd_work_q, bcd_work_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [11:0]        bcd_q, bcd_d;
    logic               start_pend_q, start_pend_d;
    logic [FLASH_W-1:0] flash_timer_q, flash_timer_d;
    logic               outcome_q, outcome_d;

    logic [11:0]        bcd_adj;
    logic [7:0]         digit_seg;
    logic [3:0]         flash_nib;

    function automatic logic [11:0] add3_nibbles(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Active-low segment patterns with dp (bit 7) held off.
    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            4'hF:    s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    always_comb begin
        scan_cnt_d  = scan_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d  = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end
    end

    // Converter works from latched_score_q so a mid-run score change cannot corrupt it.
    always_comb begin
        conv_state_d    = conv_state_q;
        latched_score_d = latched_score_q;
        bcd_work_d      = bcd_work_q;
        bit_cnt_d       = bit_cnt_q;
        bcd_d           = bcd_q;
        start_pend_d    = start_pend_q;
        bcd_adj         = add3_nibbles(bcd_work_q);
        case (conv_state_q)
            CONV_IDLE: begin
                if (score != latched_score_q || start_pend_q) begin
                    conv_state_d = CONV_LOAD;
                end
            end
            CONV_LOAD: begin
                latched_score_d = score;
                bcd_work_d      = '0;
                bit_cnt_d       = '0;
                start_pend_d    = 1'b0;
                conv_state_d    = CONV_SHIFT;
            end
            CONV_SHIFT: begin
                bcd_work_d = (bcd_adj << 1) | {11'd0, latched_score_q[3'd7 - bit_cnt_q]};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    conv_state_d = CONV_DONE;
                end
            end
            CONV_DONE: begin
                bcd_d        = bcd_work_q;
                conv_state_d = CONV_IDLE;
            end
            default: conv_state_d = CONV_IDLE;
        endcase
    end

    always_comb begin
        flash_timer_d = flash_timer_q;
        outcome_d     = outcome_q;
        if (round_tick) begin
            flash_timer_d = FLASH_LOAD;
            outcome_d     = round_res;
        end else if (flash_timer_q != '0) begin
            flash_timer_d = flash_timer_q - 1'b1;
        end
    end

    // Leading-zero blanking: tens only blank when hundreds is blank too.
    always_comb begin
        digit_seg = 8'hFF;
        case (digit_idx_q)
            2'd0: digit_seg = seg_encode(bcd_q[3:0]);
            2'd1: begin
                if (bcd_q[11:8] != 4'd0 || bcd_q[7:4] != 4'd0) begin
                    digit_seg = seg_encode(bcd_q[7:4]);
                end
            end
            2'd2: begin
                if (bcd_q[11:8] != 4'd0) begin
                    digit_seg = seg_encode(bcd_q[11:8]);
                end
            end
            default: digit_seg = seg_encode(pattern);
        endcase

        an_d  = ~(4'b0001 << digit_idx_q);
        seg_d = digit_seg;

        flash_nib = 4'h0;
        if (flash_timer_d != '0) begin
            flash_nib = outcome_d ? 4'hF : 4'hA;
        end
        led_d = {flash_nib, pattern};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q      <= '0;
            digit_idx_q     <= 2'd0;
            an_q            <= 4'hF;
            seg_q           <= 8'hFF;
            led_q           <= 8'h00;
            conv_state_q    <= CONV_IDLE;
            latched_score_q <= 8'd0;
            bcd_work_q      <= 12'd0;
            bit_cnt_q       <= 3'd0;
            bcd_q           <= 12'd0;
            start_pend_q    <= 1'b1;
            flash_timer_q   <= '0;
            outcome_q       <= 1'b0;
        end else begin
            scan_cnt_q      <= scan_cnt_d;
            digit_idx_q     <= digit_idx_d;
            an_q            <= an_d;
            seg_q           <= seg_d;
            led_q           <= led_d;
            conv_state_q    <= conv_state_d;
            latched_score_q <= latched_score_d;
            bcd_work_q      <= bcd_work_d;
            bit_cnt_q       <= bit_cnt_d;
            bcd_q           <= bcd_d;
            start_pend_q    <= start_pend_d;
            flash_timer_q   <= flash_timer_d;
            outcome_q       <= outcome_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign LED = led_q;

endmodule

// File: tb/tb_score_display_driver.sv
// Bench for score_display_driver: stimulus pushes expected frames/LED runs/patterns into queues,
// independent monitor processes pop and compare as the DUT presents them.
module tb_score_display_driver;

    localparam int SCAN_DIV  = 4;
    localparam int FLASH_LEN = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] score;
    logic [3:0] pattern;
    logic       round_tick;
    logic       round_res;
    logic [3:0] AN;
    logic [7:0] SEG;
    logic [7:0] LED;

    always #5 clk = ~clk;

    score_display_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .FLASH_LEN (FLASH_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .score      (score),
        .pattern    (pattern),
        .round_tick (round_tick),
        .round_res  (round_res),
        .AN         (AN),
        .SEG        (SEG),
        .LED        (LED)
    );

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        bit         anchor;
    } frame_t;

    typedef struct {
        logic [3:0] val;
        int         len;
    } run_t;

    frame_t     disp_q[$];
    run_t       led_q[$];
    logic [3:0] pat_q[$];
    int         rst_pending = 0;

    int total = 0;
    int bad   = 0;
    bit mon_en   = 1'b0;
    bit legal_en = 1'b0;

    // Reset monitor: outputs must clear asynchronously.
    always @(posedge rst) begin
        #1;
        if (rst_pending > 0) begin
            rst_pending--;
            total++;
            if (AN !== 4'hF || SEG !== 8'hFF || LED !== 8'h00) begin
                bad++;
                $display("FAIL reset_outputs: got AN=%h SEG=%h LED=%h, want AN=f SEG=ff LED=00", AN, SEG, LED);
            end
        end
    end

    // Display monitor.
    logic [3:0] prev_an  = 4'hF;
    int         hold     = 0;
    int         wait_cnt = 0;
    frame_t     exp_f;
    bit         legal_ok;

    always @(negedge clk) begin
        if (mon_en) begin
            if (AN != prev_an) begin
                if (prev_an != 4'hF && AN != 4'hF) begin
                    total++;
                    if (hold != SCAN_DIV) begin
                        bad++;
                        $display("FAIL scan_hold: AN=%h held %0d clk, want %0d", prev_an, hold, SCAN_DIV);
                    end
                end
                if (AN != 4'hF) begin
                    total++;
                    if ($countones(~AN) != 1) begin
                        bad++;
                        $display("FAIL an_onehot: AN=%h, want exactly one low bit", AN);
                    end
                    if (disp_q.size() > 0) begin
                        if (!disp_q[0].anchor || disp_q[0].an == AN) begin
                            exp_f    = disp_q.pop_front();
                            wait_cnt = 0;
                            total++;
                            if (AN !== exp_f.an || SEG !== exp_f.seg) begin
                                bad++;
                                $display("FAIL digit_frame: got AN=%h SEG=%h, want AN=%h SEG=%h",
                                         AN, SEG, exp_f.an, exp_f.seg);
                            end
                        end
                    end
                end
                hold    = 1;
                prev_an = AN;
            end else begin
                hold++;
            end

            // Digits 0..2 may only ever show a digit of 255, 100 or 42 while this is armed.
            if (legal_en && AN != 4'hF && AN != 4'h7) begin
                case (AN)
                    4'hE:    legal_ok = SEG inside {8'h92, 8'hC0, 8'hA4};
                    4'hD:    legal_ok = SEG inside {8'h92, 8'hC0, 8'h99};
                    4'hB:    legal_ok = SEG inside {8'hA4, 8'hF9, 8'hFF};
                    default: legal_ok = 1'b0;
                endcase
                total++;
                if (!legal_ok) begin
                    bad++;
                    $display("FAIL no_partial: AN=%h SEG=%h is not a digit of 255/100/42", AN, SEG);
                end
            end

            if (disp_q.size() > 0) begin
                wait_cnt++;
                if (wait_cnt > 120) begin
                    total++;
                    bad++;
                    $display("FAIL disp_timeout: %0d frames never seen, next want AN=%h SEG=%h",
                             disp_q.size(), disp_q[0].an, disp_q[0].seg);
                    disp_q.delete();
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Flash monitor: measures runs of LED[7:4].
    logic [3:0] prev_fl = 4'h0;
    int         run_len = 0;
    run_t       exp_r;

    always @(negedge clk) begin
        if (mon_en) begin
            if (LED[7:4] != prev_fl) begin
                total++;
                if (led_q.size() > 0) begin
                    exp_r = led_q.pop_front();
                    if (prev_fl !== exp_r.val || (exp_r.len >= 0 && run_len != exp_r.len)) begin
                        bad++;
                        $display("FAIL led_run: got LED[7:4]=%h for %0d clk, want %h for %0d clk",
                                 prev_fl, run_len, exp_r.val, exp_r.len);
                    end
                end else begin
                    bad++;
                    $display("FAIL led_unexpected: LED[7:4] %h -> %h with no change expected", prev_fl, LED[7:4]);
                end
                prev_fl = LED[7:4];
                run_len = 1;
            end else begin
                run_len++;
            end
        end
    end

    // Pattern mirror monitor.
    logic [3:0] prev_pat = 4'h0;
    logic [3:0] exp_p;

    always @(negedge clk) begin
        if (mon_en && LED[3:0] != prev_pat) begin
            total++;
            if (pat_q.size() > 0) begin
                exp_p = pat_q.pop_front();
                if (LED[3:0] !== exp_p) begin
                    bad++;
                    $display("FAIL led_pattern: got LED[3:0]=%h, want %h", LED[3:0], exp_p);
                end
            end else begin
                bad++;
                $display("FAIL led_pattern_unexpected: LED[3:0] %h -> %h", prev_pat, LED[3:0]);
            end
            prev_pat = LED[3:0];
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_group(input logic [7:0] ones, input logic [7:0] tens,
                              input logic [7:0] hund, input logic [7:0] pat);
        frame_t f;
        f.an = 4'hE; f.seg = ones; f.anchor = 1'b1; disp_q.push_back(f);
        f.an = 4'hD; f.seg = tens; f.anchor = 1'b0; disp_q.push_back(f);
        f.an = 4'hB; f.seg = hund; f.anchor = 1'b0; disp_q.push_back(f);
        f.an = 4'h7; f.seg = pat;  f.anchor = 1'b0; disp_q.push_back(f);
    endtask

    task automatic push_run(input logic [3:0] val, input int len);
        run_t r;
        r.val = val;
        r.len = len;
        led_q.push_back(r);
    endtask

    task automatic drain_disp();
        int n = 0;
        while (disp_q.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        score      = 8'd0;
        pattern    = 4'h5;
        round_tick = 1'b0;
        round_res  = 1'b0;
        cycles(2);

        // Reset mid-cycle, release with score 0.
        rst_pending++;
        pat_q.push_back(4'h5);
        push_group(8'hC0, 8'hFF, 8'hFF, 8'h92);
        #2 rst = 1'b1;
        #1 mon_en = 1'b1;
        cycles(3);
        rst = 1'b0;
        drain_disp();

        // Conversions.
        score = 8'd237;
        cycles(14);
        push_group(8'hF8, 8'hB0, 8'hA4, 8'h92);
        drain_disp();

        score = 8'd5;
        cycles(14);
        push_group(8'h92, 8'hFF, 8'hFF, 8'h92);
        drain_disp();

        score = 8'd255;
        cycles(14);
        push_group(8'h92, 8'h92, 8'hA4, 8'h92);
        drain_disp();

        // Score change while a conversion is running.
        legal_en = 1'b1;
        score = 8'd100;
        cycles(3);
        score = 8'd42;
        cycles(40);
        legal_en = 1'b0;
        push_group(8'hA4, 8'h99, 8'hFF, 8'h92);
        drain_disp();

        // Scan order and pattern digit.
        pat_q.push_back(4'hC);
        score   = 8'd123;
        pattern = 4'hC;
        cycles(14);
        push_group(8'hB0, 8'hA4, 8'hF9, 8'hC6);
        drain_disp();

        // Single hit flash.
        push_run(4'h0, -1);
        push_run(4'hF, 6);
        round_res  = 1'b1;
        round_tick = 1'b1;
        cycles(1);
        round_tick = 1'b0;
        cycles(12);

        // Miss then hit three clk later: last tick wins.
        push_run(4'h0, -1);
        push_run(4'hA, 3);
        push_run(4'hF, 6);
        round_res  = 1'b0;
        round_tick = 1'b1;
        cycles(1);
        round_tick = 1'b0;
        cycles(2);
        round_res  = 1'b1;
        round_tick = 1'b1;
        cycles(1);
        round_tick = 1'b0;
        cycles(12);

        // round_tick held for three clk keeps reloading.
        push_run(4'h0, -1);
        push_run(4'hF, 8);
        round_res  = 1'b1;
        round_tick = 1'b1;
        cycles(3);
        round_tick = 1'b0;
        cycles(12);

        // Reset during flash and conversion.
        push_run(4'h0, -1);
        push_run(4'hF, -1);
        pat_q.push_back(4'h0);
        pat_q.push_back(4'hC);
        rst_pending++;
        score      = 8'd77;
        round_res  = 1'b1;
        round_tick = 1'b1;
        cycles(1);
        round_tick = 1'b0;
        cycles(3);
        #2 rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(14);
        push_group(8'hF8, 8'hF8, 8'hFF, 8'hC6);
        drain_disp();

        cycles(5);
        total++;
        if (disp_q.size() != 0 || led_q.size() != 0 || pat_q.size() != 0 || rst_pending != 0) begin
            bad++;
            $display("FAIL leftover_expect: disp=%0d led=%0d pat=%0d rst=%0d still pending, want all 0",
                     disp_q.size(), led_q.size(), pat_q.size(), rst_pending);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
